// File: rtl/pcap_framer.sv
// pcap_framer: wraps each FIFO packet in a 4-word pcap record header and
// streams header plus snap-limited payload as one Avalon-ST packet.
module pcap_framer #(
    parameter int SNAPLEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [31:0]      ts_sec,
    input  logic [31:0]      ts_usec,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [31:0]      st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_sop,
    output logic             st_eop,
    output logic [1:0]       st_empty
);

    localparam int CW = LEN_W - 1;
    localparam logic [LEN_W-1:0] SNAP = LEN_W'(SNAPLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_DROP,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [31:0]      sec_q, usec_q;
    logic [LEN_W-1:0] len_q, incl_q;
    logic [CW-1:0]    inc_q, drop_q;
    logic [CW-1:0]    wcnt_q, dcnt_q;
    logic [1:0]       hcnt_q;

    logic [LEN_W-1:0] incl_c;
    logic [CW-1:0]    inc_c, tot_c, drop_c;

    // word counts are ceil(bytes/4)
    assign incl_c = (pkt_len > SNAP) ? SNAP : pkt_len;
    assign inc_c  = {1'b0, incl_c[LEN_W-1:2]} + CW'(|incl_c[1:0]);
    assign tot_c  = {1'b0, pkt_len[LEN_W-1:2]} + CW'(|pkt_len[1:0]);
    assign drop_c = tot_c - inc_c;

    logic        load;
    logic        last_w, last_d;
    logic [1:0]  pad;
    logic [31:0] hdr_w;

    assign load   = !st_valid || st_ready;
    assign last_w = (wcnt_q == inc_q - CW'(1));
    assign last_d = (dcnt_q == drop_q - CW'(1));
    assign pad    = 2'd0 - incl_q[1:0];
    assign busy   = (state != S_IDLE);

    always_comb begin
        hdr_w = sec_q;
        unique case (hcnt_q)
            2'd0:    hdr_w = sec_q;
            2'd1:    hdr_w = usec_q;
            2'd2:    hdr_w = 32'(incl_q);
            default: hdr_w = 32'(len_q);
        endcase
    end

    logic        ld, nv, ns, ne;
    logic [31:0] nd;
    logic [1:0]  nm;
    logic        hinc, winc, dinc, fin;

    always_comb begin
        state_nx   = state;
        fifo_rdreq = 1'b0;
        ld         = 1'b0;
        nv         = 1'b0;
        ns         = 1'b0;
        ne         = 1'b0;
        nd         = '0;
        nm         = '0;
        hinc       = 1'b0;
        winc       = 1'b0;
        dinc       = 1'b0;
        fin        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_HDR;
            end
            S_HDR: begin
                ld = load;
                if (load) begin
                    nv   = 1'b1;
                    nd   = hdr_w;
                    ns   = (hcnt_q == 2'd0);
                    ne   = (hcnt_q == 2'd3) && (inc_q == '0);
                    hinc = 1'b1;
                    if (hcnt_q == 2'd3) begin
                        if (inc_q != '0)       state_nx = S_PAY;
                        else if (drop_q != '0) state_nx = S_DROP;
                        else                   state_nx = S_FIN;
                    end
                end
            end
            S_PAY: begin
                // an empty FIFO on a load drains the register into a bubble
                ld = load;
                if (load && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    nv         = 1'b1;
                    nd         = fifo_q;
                    ne         = last_w;
                    nm         = last_w ? pad : 2'd0;
                    winc       = 1'b1;
                    if (last_w) state_nx = (drop_q != '0) ? S_DROP : S_FIN;
                end
            end
            S_DROP: begin
                ld = load;
                if (!fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    dinc       = 1'b1;
                    if (last_d) state_nx = S_FIN;
                end
            end
            S_FIN: begin
                ld = load;
                if (load) begin
                    fin      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fin;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q  <= '0;
            usec_q <= '0;
            len_q  <= '0;
            incl_q <= '0;
            inc_q  <= '0;
            drop_q <= '0;
            hcnt_q <= '0;
            wcnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                sec_q  <= ts_sec;
                usec_q <= ts_usec;
                len_q  <= pkt_len;
                incl_q <= incl_c;
                inc_q  <= inc_c;
                drop_q <= drop_c;
                hcnt_q <= '0;
                wcnt_q <= '0;
                dcnt_q <= '0;
            end
            if (hinc) hcnt_q <= hcnt_q + 2'd1;
            if (winc) wcnt_q <= wcnt_q + CW'(1);
            if (dinc) dcnt_q <= dcnt_q + CW'(1);
        end
    end

    // output register; data fields only move on a real beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid <= 1'b0;
            st_data  <= '0;
            st_sop   <= 1'b0;
            st_eop   <= 1'b0;
            st_empty <= '0;
        end else if (ld) begin
            st_valid <= nv;
            if (nv) begin
                st_data  <= nd;
                st_sop   <= ns;
                st_eop   <= ne;
                st_empty <= nm;
            end
        end
    end

endmodule

// File: tb/tb_pcap_framer.sv
// tb_pcap_framer: directed and randomized records against a queue-based
// FIFO/sink model and a record-level expectation built from the length rules.
module tb_pcap_framer;

    localparam int SNAP = 66;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [31:0] ts_sec = '0;
    logic [31:0] ts_usec = '0;
    logic        busy, done, fifo_rdreq;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop, st_eop;
    logic [1:0]  st_empty;

    pcap_framer #(.SNAPLEN(SNAP), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len),
        .ts_sec(ts_sec), .ts_usec(ts_usec), .busy(busy), .done(done),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
    } beat_t;

    // sink monitor state
    beat_t beats[$];
    beat_t prev;
    logic  prev_stall = 1'b0;
    int    pops = 0;
    int    stall_viol = 0;
    int    rd_viol = 0;

    // source / FIFO model state
    logic [31:0] src[$];
    logic [31:0] fifo[$];
    int src_rd = 0;
    int pop_done = 0;
    int feed_div = 0;
    int rcyc = 0;
    int flush_seen = 0;

    // written by the stimulus only
    int feed_mode = 0;
    int ready_mode = 0;
    int flush_seq = 0;
    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_rdreq) begin
                pops++;
                if (fifo_empty) rd_viol++;
            end
            if (prev_stall && (!st_valid || st_data !== prev.d ||
                st_sop !== prev.sop || st_eop !== prev.eop ||
                st_empty !== prev.emp))
                stall_viol++;
            prev = '{st_data, st_sop, st_eop, st_empty};
            prev_stall = st_valid && !st_ready;
            if (st_valid && st_ready) beats.push_back(prev);
        end
    end

    always @(posedge clk) begin
        #1;
        if (flush_seq != flush_seen) begin
            flush_seen = flush_seq;
            fifo.delete();
            src_rd = src.size();
            pop_done = pops;
        end
        while (pop_done < pops) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_done++;
        end
        if (feed_mode == 0) begin
            while (src_rd < src.size()) begin
                fifo.push_back(src[src_rd]);
                src_rd++;
            end
        end else begin
            feed_div++;
            if (feed_div >= 3 && src_rd < src.size()) begin
                fifo.push_back(src[src_rd]);
                src_rd++;
                feed_div = 0;
            end
        end
        rcyc++;
        case (ready_mode)
            0:       st_ready = 1'b1;
            1:       st_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
            default: st_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = (fifo.size() == 0);
        fifo_q = fifo_empty ? 32'hdead_beef : fifo[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // base != 0 gives payload words base, base+1, ...; else random
    task automatic run_rec(input int len, input logic [31:0] sec,
                           input logic [31:0] usec, input int base,
                           input int fmode, input int rmode);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int incl, inc, tot, drop, nb;
        int b0, p0, sv0, rv0, cyc;
        bit eop_prev;
        incl = (len > SNAP) ? SNAP : len;
        inc  = (incl + 3) / 4;
        tot  = (len + 3) / 4;
        drop = tot - inc;
        exp_w.push_back(sec);
        exp_w.push_back(usec);
        exp_w.push_back(32'(incl));
        exp_w.push_back(32'(len));
        feed_mode = fmode;
        ready_mode = rmode;
        for (int i = 0; i < tot; i++) begin
            w = (base != 0) ? 32'(base + i) : $urandom;
            src.push_back(w);
            if (i < inc) exp_w.push_back(w);
        end
        nb = exp_w.size();
        b0 = beats.size();
        p0 = pops;
        sv0 = stall_viol;
        rv0 = rd_viol;
        @(posedge clk);
        #1;
        start = 1'b1;
        pkt_len = 16'(len);
        ts_sec = sec;
        ts_usec = usec;
        @(posedge clk);
        #1;
        start = 1'b0;
        pkt_len = 16'($urandom);
        ts_sec = $urandom;
        ts_usec = $urandom;
        step();
        chk("busy_after_start", 32'(busy), 1);
        chk("h0_not_yet", 32'(st_valid), 0);
        step();
        chk("h0_valid", 32'(st_valid), 1);
        chk("h0_data", st_data, sec);
        chk("h0_sop", 32'(st_sop), 1);
        cyc = 0;
        eop_prev = 1'b0;
        while (!done && cyc < 3000) begin
            step();
            cyc++;
            if (eop_prev && drop == 0) chk("done_after_eop", 32'(done), 1);
            eop_prev = st_valid && st_ready && st_eop;
            if (cyc == 5 && busy && !done) begin
                start = 1'b1;
                pkt_len = 16'd4;
            end else if (cyc == 6) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 1);
        chk("busy_fall", 32'(busy), 0);
        if (fmode == 0 && rmode == 0) chk("back_to_back", 32'(cyc), 32'(nb + drop));
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("beat_count", 32'(beats.size() - b0), 32'(nb));
        for (int i = 0; i < nb && b0 + i < beats.size(); i++) begin
            chk($sformatf("data[%0d]", i), beats[b0+i].d, exp_w[i]);
            chk($sformatf("sop[%0d]", i), 32'(beats[b0+i].sop), 32'(i == 0));
            chk($sformatf("eop[%0d]", i), 32'(beats[b0+i].eop), 32'(i == nb - 1));
            chk($sformatf("empty[%0d]", i), 32'(beats[b0+i].emp),
                (i == nb - 1) ? 32'((4 - incl % 4) % 4) : 32'd0);
        end
        chk("pop_count", 32'(pops - p0), 32'(tot));
        chk("fifo_drained", 32'(fifo.size() + src.size() - src_rd), 0);
        chk("stall_hold", 32'(stall_viol - sv0), 0);
        chk("rdreq_on_empty", 32'(rd_viol - rv0), 0);
    endtask

    initial begin
        int b0, cyc, len;
        repeat (3) step();
        chk("rst_valid", 32'(st_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdreq", 32'(fifo_rdreq), 0);
        chk("rst_data", st_data, 0);
        reset = 1'b1;
        step();

        run_rec(32, 32'd5, 32'd7, 10, 0, 0);
        run_rec(6, $urandom, $urandom, 0, 0, 0);
        run_rec(80, $urandom, $urandom, 0, 0, 0);
        run_rec(100, $urandom, $urandom, 0, 0, 1);
        run_rec(32, $urandom, $urandom, 0, 0, 1);
        run_rec(40, $urandom, $urandom, 0, 1, 0);
        run_rec(0, $urandom, $urandom, 0, 0, 0);
        run_rec(SNAP, $urandom, $urandom, 0, 0, 0);
        run_rec(SNAP + 1, $urandom, $urandom, 0, 1, 2);

        // reset in the middle of the payload
        for (int i = 0; i < 16; i++) src.push_back($urandom);
        feed_mode = 0;
        ready_mode = 0;
        b0 = beats.size();
        @(posedge clk);
        #1;
        start = 1'b1;
        pkt_len = 16'd64;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (beats.size() - b0 < 7 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("mid_pay_reached", 32'(beats.size() - b0 >= 7), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(st_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_rdreq", 32'(fifo_rdreq), 0);
        chk("rst_mid_data", st_data, 0);
        chk("rst_mid_flags", {29'd0, st_sop, st_eop, st_empty != 2'd0}, 0);
        flush_seq++;
        repeat (3) step();
        reset = 1'b1;
        step();
        run_rec(20, $urandom, $urandom, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 150);
            run_rec(len, $urandom, $urandom, 0,
                    $urandom_range(0, 1), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pcap_framer.md
Name: pcap_framer

Overview:
- Downstream neighbour of the burst read controller; consumes the 32-bit packet words that controller pushes into the shared show-ahead FIFO.
- Prepends a 4-word pcap record header (ts_sec, ts_usec, incl_len, orig_len) to each packet.
- Emits header plus payload as one Avalon-ST packet toward the capture sink.
- Enforces a snap length: payload words beyond it are popped from the FIFO and discarded.

Parameters:
- SNAPLEN, 1518, maximum captured bytes per record (incl_len cap); must be ≥4.
- LEN_W, 16, width of the byte-length fields.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches pkt_len, ts_sec and ts_usec
- pkt_len  in  LEN_W  original packet length in bytes; equals the byte count the read controller writes into the FIFO, rounded up to whole words
- ts_sec  in  32  capture timestamp, seconds
- ts_usec  in  32  capture timestamp, microseconds
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final FIFO word is consumed
- fifo_q  in  32  FIFO head word; show-ahead, valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rdreq  out  1  pops the head word; only asserted while fifo_empty=0
- st_data  out  32  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  sink ready; beat transfers when st_valid & st_ready
- st_sop  out  1  high on header word 0
- st_eop  out  1  high on the final beat of the record
- st_empty  out  2  number of unused trailing bytes, valid with st_eop

Behaviour:
- Reset (async, reset=0):
  - all outputs 0 and FSM returns to IDLE;
  - latched fields cleared;
  - the FIFO is not flushed by this block.
- Length arithmetic at start:
  - incl = min(pkt_len, SNAPLEN);
  - inc_words = ceil(incl/4);
  - tot_words = ceil(pkt_len/4);
  - drop_words = tot_words − inc_words.
  - Counters are LEN_W−1 bits wide; no wrap is possible.
- Output register:
  - st_* form a single register stage;
  - loaded when st_valid=0 or st_ready=1;
  - st_data/st_sop/st_eop/st_empty hold stable while st_valid=1 and st_ready=0.
- FSM:
  - IDLE: start=1 → latch inputs, go to HDR. A start pulse at any other time is ignored.
  - HDR: emits H0=ts_sec, H1=ts_usec, H2=incl, H3=pkt_len (zero-extended to 32 bits), one word per output-register load.
    - Latency: start at edge N → H0 valid at N+1 when st_ready is held high.
    - After H3: go to PAY if inc_words>0, else DROP if drop_words>0, else FIN.
  - PAY: on each output-register load with fifo_empty=0, assert fifo_rdreq and move fifo_q into st_data.
    - If fifo_empty=1, insert a bubble (st_valid=0 after the current beat drains) and do not pop.
    - After the inc_words-th word: go to DROP if drop_words>0, else FIN.
  - DROP: assert fifo_rdreq each cycle fifo_empty=0, with no stream output, until drop_words words are popped; then go to FIN.
  - FIN: wait for the last beat to be accepted; pulse done for 1 cycle; go to IDLE. busy falls the same cycle done pulses.
- st_eop placement:
  - on the last PAY word, with st_empty = (4 − incl mod 4) mod 4;
  - if incl=0 (pkt_len=0), on H3 with st_empty=0.
- Snap cap: incl is SNAPLEN whenever pkt_len > SNAPLEN; orig_len still reports pkt_len.
- Simultaneous events:
  - A pop and an output load in the same cycle are a single rdreq.
  - st_ready=0 with FIFO non-empty in PAY: no pop occurs, so no data is lost.
  - DROP pops are independent of st_ready.
- Reset mid-record: the record is abandoned, and the partial stream is truncated without eop. The read controller's FIFO clear covers resynchronisation.

Test Plan:
1. pkt_len=32, ts=(5,7), FIFO preloaded with 10..17, st_ready=1 → beats 5,7,32,32,10..17 on consecutive cycles; sop on beat 0; eop on 17 with empty=0; 8 pops; done 1 cycle after the last beat.
2. pkt_len=6, FIFO holds 2 words → 4 header beats then 2 payload beats; eop on the second payload beat with st_empty=2; H2=H3=6.
3. SNAPLEN=8, pkt_len=20, 5 FIFO words → H2=8, H3=20; 2 payload beats (eop, empty=0); 3 more words popped with no output; FIFO empty at done.
4. pkt_len=32, st_ready toggled 1,0,0,1… mid-payload → no beat duplicated or dropped; st_data stable while stalled; exactly 8 pops.
5. FIFO fed 1 word every 3 cycles by the read controller → st_valid gaps; rdreq never asserted with fifo_empty=1; payload order preserved.
6. pkt_len=0 → 4 header beats, eop on H3, zero pops. A start pulsed while busy is ignored. Reset asserted mid-PAY → all outputs 0 immediately; the next start is framed correctly.
